// File: rtl/valve_pkg.sv
// Shared types and constants for the irrigation valve sequencer.
// Also holds the counter-width helper used by the sequencer and its channels.
package valve_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      LOCK = 2'd2,
      COOL = 2'd3
   } chan_state_t;

   localparam logic [1:0] ERR_CODE = 2'b00;
   localparam logic [1:0] NE_CODE  = 2'b01;

   localparam logic Agua = 1'b1;
   localparam logic Stop = 1'b0;

   // Counter width for a cycle-count parameter, never narrower than one bit
   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/valve_sequencer_if.sv
// Command/status bundle between the irrigation controller and the valve sequencer.
// The controller side is the master; the sequencer is the slave.
interface valve_sequencer_if;
   logic [1:0] R1;
   logic [1:0] R2;
   logic [1:0] E;
   logic [3:0] valve;
   logic [3:0] timeout;
   logic       pump_en;
   logic       fault;
   logic       busy;

   modport master (output R1, R2, E, input valve, timeout, pump_en, fault, busy);
   modport slave  (input R1, R2, E, output valve, timeout, pump_en, fault, busy);
endinterface

// File: rtl/valve_channel.sv
// One valve: IDLE/ON/LOCK/COOL state machine with its on-time and cooldown counters.
// Openings are granted by the sequencer; everything after that is decided locally.
module valve_channel
   import valve_pkg::*;
#(
   parameter int MIN_ON_CYC   = 8,
   parameter int MAX_ON_CYC   = 64,
   parameter int COOLDOWN_CYC = 6
) (
   input  logic clk,
   input  logic reset,
   input  logic req,
   input  logic grant,
   input  logic err,
   output logic valve,
   output logic timeout,
   output logic idle
);

   localparam int ON_W   = cnt_w(MAX_ON_CYC);
   localparam int COOL_W = cnt_w(COOLDOWN_CYC);
   localparam logic [ON_W-1:0]   MIN_LAST  = ON_W'(MIN_ON_CYC - 1);
   localparam logic [ON_W-1:0]   MAX_LAST  = ON_W'(MAX_ON_CYC - 1);
   localparam logic [COOL_W-1:0] COOL_LAST = COOL_W'(COOLDOWN_CYC - 1);

   chan_state_t       state, state_nx;
   logic [ON_W-1:0]   on_cnt, on_cnt_nx;
   logic [COOL_W-1:0] cool_cnt, cool_cnt_nx;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         on_cnt   <= '0;
         cool_cnt <= '0;
      end else begin
         state    <= state_nx;
         on_cnt   <= on_cnt_nx;
         cool_cnt <= cool_cnt_nx;
      end
   end

   // Close priority inside ON: error first, then a normal close, then the timeout lockout
   always_comb begin
      state_nx    = state;
      on_cnt_nx   = on_cnt;
      cool_cnt_nx = cool_cnt;
      case (state)
         IDLE: begin
            if (req && grant) begin
               state_nx  = ON;
               on_cnt_nx = '0;
            end
         end
         ON: begin
            if (err || (!req && on_cnt >= MIN_LAST)) begin
               state_nx    = COOL;
               cool_cnt_nx = '0;
            end else if (req && on_cnt == MAX_LAST) begin
               state_nx = LOCK;
            end else if (on_cnt != MAX_LAST) begin
               on_cnt_nx = on_cnt + ON_W'(1);
            end
         end
         LOCK: begin
            if (!req) begin
               state_nx    = COOL;
               cool_cnt_nx = '0;
            end
         end
         COOL: begin
            if (cool_cnt == COOL_LAST) begin
               state_nx = IDLE;
            end else begin
               cool_cnt_nx = cool_cnt + COOL_W'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign valve   = (state == ON) ? Agua : Stop;
   assign timeout = (state == LOCK);
   assign idle    = (state == IDLE);

endmodule

// File: rtl/valve_sequencer.sv
// Four-valve sequencer: staggers openings to limit pump inrush and closes everything on upstream error.
// Per-valve timing lives in valve_channel; this level arbitrates openings and merges status.
module valve_sequencer
   import valve_pkg::*;
#(
   parameter int STAGGER_CYC  = 4,
   parameter int MIN_ON_CYC   = 8,
   parameter int MAX_ON_CYC   = 64,
   parameter int COOLDOWN_CYC = 6
) (
   input logic              clk,
   input logic              reset,
   valve_sequencer_if.slave bus
);

   localparam int STAG_W = cnt_w(STAGGER_CYC);
   localparam logic [STAG_W-1:0] STAG_LAST = STAG_W'(STAGGER_CYC - 1);

   logic [3:0]        req;
   logic [3:0]        grant;
   logic [3:0]        valve_w;
   logic [3:0]        timeout_w;
   logic [3:0]        idle_w;
   logic              err;
   logic              found;
   logic [STAG_W-1:0] stagger_cnt;
   logic              fault_q;

   assign req = {bus.R2, bus.R1};
   assign err = (bus.E == ERR_CODE);

   // Only the lowest-index idle requester may be granted; if it is blocked, nobody is
   always_comb begin
      grant = '0;
      found = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (!found && idle_w[i] && req[i]) begin
            found    = 1'b1;
            grant[i] = !err && (stagger_cnt == '0);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stagger_cnt <= '0;
         fault_q     <= 1'b0;
      end else begin
         fault_q <= err;
         if (|grant) begin
            stagger_cnt <= STAG_LAST;
         end else if (stagger_cnt != '0) begin
            stagger_cnt <= stagger_cnt - STAG_W'(1);
         end
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_chan
      valve_channel #(
         .MIN_ON_CYC  (MIN_ON_CYC),
         .MAX_ON_CYC  (MAX_ON_CYC),
         .COOLDOWN_CYC(COOLDOWN_CYC)
      ) u_chan (
         .clk    (clk),
         .reset  (reset),
         .req    (req[g]),
         .grant  (grant[g]),
         .err    (err),
         .valve  (valve_w[g]),
         .timeout(timeout_w[g]),
         .idle   (idle_w[g])
      );
   end

   assign bus.valve   = valve_w;
   assign bus.timeout = timeout_w;
   assign bus.pump_en = |valve_w;
   assign bus.fault   = fault_q;
   assign bus.busy    = ~&idle_w;

endmodule
